// File: rtl/regfile_wr.sv
// rtl/regfile_wr.sv - write side of the 32x32 register file
// Capture stage holds one write-back for forwarding; commit stage writes it into storage.
module regfile_wr #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    localparam int DEPTH     = 1 << DEPTH_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DEPTH_LOG2-1:0]  wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   pend_valid,
    output logic [DEPTH_LOG2-1:0]  pend_addr,
    output logic [WIDTH-1:0]       pend_data,
    output logic [DEPTH-1:0]       wr_onehot,
    output logic [DEPTH*WIDTH-1:0] regs_flat,
    output logic [15:0]            wr_count
);

    localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

    logic                  pend_valid_q, pend_valid_d;
    logic [DEPTH_LOG2-1:0] pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0]      pend_data_q, pend_data_d;
    logic [DEPTH-1:0]      onehot_q, onehot_d;
    logic [15:0]           count_q, count_d;
    logic                  capture;

    always_comb begin
        capture      = wr_en && (wr_addr != '0);
        pend_valid_d = capture;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        onehot_d     = '0;
        if (capture) begin
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
            onehot_d    = ONE << wr_addr;
        end
        // A nonzero one-hot is exactly "a pending entry commits this edge"
        count_d = (|onehot_q) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            onehot_q     <= '0;
            count_q      <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            onehot_q     <= onehot_d;
            count_q      <= count_d;
        end
    end

    // Register 0 has no storage and is hard-wired to zero.
    assign regs_flat[0 +: WIDTH] = '0;

    for (genvar k = 1; k < DEPTH; k++) begin : g_reg
        logic [WIDTH-1:0] reg_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                reg_q <= '0;
            end else if (onehot_q[k]) begin
                reg_q <= pend_data_q;
            end
        end

        assign regs_flat[k*WIDTH +: WIDTH] = reg_q;
    end

    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign pend_data  = pend_data_q;
    assign wr_onehot  = onehot_q;
    assign wr_count   = count_q;

endmodule

// File: tb/tb_regfile_wr.sv
// tb/tb_regfile_wr.sv - randomized bench for regfile_wr against an array reference model
module tb_regfile_wr;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          pend_valid;
    logic [4:0]    pend_addr;
    logic [31:0]   pend_data;
    logic [31:0]   wr_onehot;
    logic [1023:0] regs_flat;
    logic [15:0]   wr_count;

    regfile_wr #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data),
        .wr_onehot  (wr_onehot),
        .regs_flat  (regs_flat),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_count;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_count = '0;
    endtask

    task automatic check_all(input bit full);
        check("pend_valid", 64'(pend_valid), 64'(m_valid));
        check("wr_count", 64'(wr_count), 64'(m_count));
        check("wr_onehot", 64'(wr_onehot), m_valid ? (64'd1 << m_addr) : 64'd0);
        if (m_valid) begin
            check("pend_addr", 64'(pend_addr), 64'(m_addr));
            check("pend_data", 64'(pend_data), 64'(m_data));
        end
        if (full) begin
            for (int k = 0; k < 32; k++)
                check($sformatf("reg%0d", k), 64'(regs_flat[k*32 +: 32]), 64'(m_regs[k]));
        end
    endtask

    // Drive one request, let one edge pass, advance the model by one edge, compare.
    task automatic step(input bit en, input logic [4:0] a, input logic [31:0] d, input bit full);
        @(negedge clk);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (m_valid) begin
            m_regs[m_addr] = m_data;
            m_count        = m_count + 16'd1;
        end
        if (en && a != 5'd0) begin
            m_valid = 1'b1;
            m_addr  = a;
            m_data  = d;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        check_all(full);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all(1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write to reg 5
        step(1, 5'd5, 32'hDEADBEEF, 1);
        check("single_onehot", 64'(wr_onehot), 64'h20);
        step(0, 5'd0, 32'h0, 1);
        check("single_reg5", 64'(regs_flat[5*32 +: 32]), 64'hDEADBEEF);
        check("single_count", 64'(wr_count), 64'd1);
        check("single_pend", 64'(pend_valid), 64'd0);

        // Writes to register 0 are dropped
        step(1, 5'd0, 32'hFFFFFFFF, 1);
        check("r0_pend", 64'(pend_valid), 64'd0);
        step(0, 5'd0, 32'h0, 1);
        check("r0_reg0", 64'(regs_flat[31:0]), 64'd0);
        check("r0_count", 64'(wr_count), 64'd1);

        // Back-to-back writes to reg 31
        step(1, 5'd31, 32'd1, 1);
        step(1, 5'd31, 32'd2, 1);
        step(1, 5'd31, 32'd3, 1);
        check("b2b_mid", 64'(regs_flat[31*32 +: 32]), 64'd2);
        step(0, 5'd0, 32'h0, 1);
        check("b2b_final", 64'(regs_flat[31*32 +: 32]), 64'd3);
        check("b2b_count", 64'(wr_count), 64'd4);

        // Decode sweep
        for (int k = 1; k < 32; k++) begin
            step(1, 5'(k), 32'(k + 32'h100), 1);
            check($sformatf("sweep_onehot%0d", k), 64'(wr_onehot), 64'd1 << k);
        end
        step(0, 5'd0, 32'h0, 1);
        check("sweep_count", 64'(wr_count), 64'd35);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 5'($urandom_range(0, 31)), $urandom, 1);

        // Reset mid-stream with a write pending
        step(1, 5'd7, 32'hA5A5A5A5, 1);
        #1;
        rst_n = 1'b0;
        wr_en = 1'b0;
        #1;
        model_reset();
        check_all(1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 1);
        check("rst_discard", 64'(regs_flat[7*32 +: 32]), 64'd0);

        // Count wrap after 65536 commits
        for (int i = 0; i < 65536; i++)
            step(1, 5'($urandom_range(1, 31)), $urandom, 0);
        step(0, 5'd0, 32'h0, 1);
        check("wrap_count", 64'(wr_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr.md
# regfile_wr

Write side of the CPU's 32×32 general-purpose register file. It accepts one write-back request per cycle from the WB stage and decodes the 5-bit destination into a 32-way one-hot enable. Each request is held for one cycle in a pending register so the ID stage can forward from it, then committed into the storage array. The whole array is exported as a flat bus for the per-bit 32-to-1 read-mux trees.

## Interface
Parameters:
- `WIDTH`, 32, register data width.
- `DEPTH_LOG2`, 5, address width; the array holds 2^DEPTH_LOG2 registers.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wr_en`  in  1  write-back request valid this cycle.
- `wr_addr`  in  5  destination register number.
- `wr_data`  in  WIDTH  write-back data.
- `pend_valid`  out  1  pending write held and not yet committed.
- `pend_addr`  out  5  address of the pending write.
- `pend_data`  out  WIDTH  data of the pending write.
- `wr_onehot`  out  32  registered one-hot decode of `pend_addr`; all zero when `pend_valid`=0.
- `regs_flat`  out  32*WIDTH  committed contents; register k occupies bits [k*WIDTH +: WIDTH].
- `wr_count`  out  16  count of committed writes, wraps modulo 2^16.

## Operation
- Two-stage pipeline: capture stage, then commit stage.
- Capture (edge N): if `wr_en`=1 and `wr_addr`≠0:
  - `pend_valid`←1, `pend_addr`←`wr_addr`, `pend_data`←`wr_data`.
  - `wr_onehot`←(1<<`wr_addr`).
  - Otherwise `pend_valid`←0 and `wr_onehot`←0. `pend_addr`/`pend_data` hold their last values and are don't-care while invalid.
- Commit (same edge N): if `pend_valid` was 1 before the edge:
  - The register selected by `wr_onehot` takes `pend_data`.
  - `wr_count` increments by 1.
- Decode is one-hot. At most one bit of `wr_onehot` is ever set, and bit 0 is never set.
- Register 0 always reads zero in `regs_flat`. Writes addressed to 0 are dropped at capture: no pending entry, no count increment.
- The block never stalls; a new request is accepted every cycle.
- Back-to-back writes to the same address: each commits in order, so the later data is the final value.
- Simultaneous capture and commit to the same address:
  - The commit uses the old pending entry.
  - The new entry replaces the pending register.
  - Nothing is lost.
- `wr_count` wraps from 0xFFFF to 0x0000 with no flag.
- Reset (assertion at any time, including mid-operation):
  - Immediately clears all 31 writable registers to 0.
  - `pend_valid`=0, `pend_addr`=0, `pend_data`=0, `wr_onehot`=0, `wr_count`=0.
  - An in-flight pending write is discarded and never committed.
  - After deassertion, the first rising edge is a normal capture edge.

## Timing
- Capture latency: a request at edge N appears on `pend_*`/`wr_onehot` during cycle N+1.
- Commit latency: the same request is written at edge N+1 and is visible on `regs_flat` during cycle N+2.
- Forwarding window: exactly one cycle (N+1). The consumer compares against `pend_addr` while `pend_valid`=1; this block has no forwarding mux.
- `regs_flat` is driven directly from the storage flops, with no combinational path from the `wr_*` inputs.
- All outputs are registered.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with a write pending.
  - `regs_flat`=0, `pend_valid`=0, `wr_onehot`=0, `wr_count`=0 immediately.
  - After release, the discarded write never appears.
- Single write: `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF at edge N.
  - Cycle N+1: `pend_valid`=1, `wr_onehot`=0x00000020.
  - Cycle N+2: reg 5 = 0xDEADBEEF, `wr_count`=1, `pend_valid`=0.
- Register 0: `wr_en`=1, `wr_addr`=0, `wr_data`=0xFFFFFFFF.
  - `pend_valid` stays 0, reg 0 reads 0, `wr_count` unchanged.
- Back-to-back same address: three consecutive writes to reg 31 of 1, 2, 3.
  - Reg 31 reads 1, 2, 3 on successive cycles.
  - Final value 3, `wr_count`=3.
- Decode sweep: write value k+0x100 to each address k=1..31 on consecutive cycles.
  - `wr_onehot` walks 1<<k, one bit per cycle.
  - All 31 registers hold their values, `wr_count`=31.
- Count wrap: preload via 65536 writes.
  - `wr_count` returns to 0x0000 with no other side effect.
